// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, d = x - y - b_in, one bit per clock, LSB first.
// A single full-subtractor cell and a registered borrow process the operands.
// Operands are captured with a start/busy/done handshake.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only when busy=0 (IDLE or DONE state)
//   x, y   - minuend / subtrahend, captured on the accepting edge
//   b_in   - borrow-in, captured on the accepting edge
//   busy   - high while bits are being shifted
//   done   - one-cycle pulse, d/b_out/ovf hold a fresh result
//   d      - difference mod 2^WIDTH
//   b_out  - unsigned borrow-out (x < y + b_in)
//   ovf    - two's-complement overflow of the subtraction
module serial_sub #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] x_sh_reg;
  logic [WIDTH-1:0] y_sh_reg;
  logic             x_msb_reg;
  logic             y_msb_reg;
  logic             b_reg;
  logic [CNT_W-1:0] cnt_reg;
  // Bits already produced; the newest bit enters at the top, so after the
  // last shift {d_i, acc_reg} is the LSB-aligned result.
  logic [WIDTH-2:0] acc_reg;
  logic [WIDTH-1:0] d_reg;
  logic             b_out_reg;
  logic             ovf_reg;
  logic             busy_reg;
  logic             done_reg;

  // Full-subtractor cell on the current bit (operands are shifted right,
  // so bit 0 of each shift register is bit i of the captured operand).
  logic             xi;
  logic             yi;
  logic             di;
  logic             b_next;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;
  logic             accept;

  assign xi       = x_sh_reg[0];
  assign yi       = y_sh_reg[0];
  assign di       = xi ^ yi ^ b_reg;
  assign b_next   = (~xi & yi) | (~(xi ^ yi) & b_reg);
  assign acc_next = {di, acc_reg};
  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
  assign accept   = start && (state_reg != SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_sh_reg  <= '0;
      y_sh_reg  <= '0;
      x_msb_reg <= 1'b0;
      y_msb_reg <= 1'b0;
      b_reg     <= 1'b0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      d_reg     <= '0;
      b_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (accept) begin
            // The MSBs are kept aside because the shift registers lose
            // them before the overflow decision is made.
            x_sh_reg  <= x;
            y_sh_reg  <= y;
            x_msb_reg <= x[WIDTH-1];
            y_msb_reg <= y[WIDTH-1];
            b_reg     <= b_in;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end

        SHIFT: begin
          x_sh_reg <= {1'b0, x_sh_reg[WIDTH-1:1]};
          y_sh_reg <= {1'b0, y_sh_reg[WIDTH-1:1]};
          acc_reg  <= acc_next[WIDTH-1:1];
          b_reg    <= b_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_bit) begin
            // Outputs only update here, so they hold through the next SHIFT.
            d_reg     <= acc_next;
            b_out_reg <= b_next;
            ovf_reg   <= (x_msb_reg != y_msb_reg) && (di != x_msb_reg);
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign d     = d_reg;
  assign b_out = b_out_reg;
  assign ovf   = ovf_reg;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         b_out;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int xv, input int yv, input int bv,
                                output logic [W-1:0] ed, output logic eb,
                                output logic eo);
    int diff;
    int sx;
    int sy;
    int sd;
    diff = xv - yv - bv;
    ed   = W'(diff & ((1 << W) - 1));
    eb   = (diff < 0);
    sx   = (xv >= (1 << (W - 1))) ? xv - (1 << W) : xv;
    sy   = (yv >= (1 << (W - 1))) ? yv - (1 << W) : yv;
    sd   = sx - sy - bv;
    eo   = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; returns at the done cycle (or after a cycle budget).
  // With scramble set, start and the operand inputs are disturbed while busy.
  task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic bv, input bit scramble,
                       output int lat, output int busy_cycles);
    x = xv; y = yv; b_in = bv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      if (scramble) begin
        if (lat == 1) begin start = 1'b1; x = 4'd15; y = 4'd0; b_in = 1'b1; end
        else begin start = 1'b0; x = W'($urandom); y = W'($urandom); b_in = 1'($urandom); end
      end
      tick();
      lat++;
    end
    start = 1'b0;
    $display("op x=%0d y=%0d b_in=%0d -> d=%0d b_out=%0d ovf=%0d lat=%0d", xv, yv, bv, d, b_out, ovf, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, d, b_out, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b d=%0d b_out=%b ovf=%b required all 0", busy, done, d, b_out, ovf);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] vx[5] = '{4'd7, 4'd3, 4'd0, 4'd8, 4'd7};
    logic [W-1:0] vy[5] = '{4'd3, 4'd7, 4'd0, 4'd1, 4'd15};
    logic         vb[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ed;
    logic eb, eo;
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(vx[i], vy[i], vb[i], 1'b0, lat, bc);
      model(int'(vx[i]), int'(vy[i]), int'(vb[i]), ed, eb, eo);
      checks++;
      if (done !== 1'b1 || lat != W || bc != W) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got done=%b lat=%0d busy_cycles=%0d required 1 %0d %0d", i, done, lat, bc, W, W);
      end
      checks++;
      if (d !== ed || b_out !== eb || ovf !== eo) begin
        errors++;
        $display("FAIL directed_result[%0d]: got d=%0d b_out=%b ovf=%b required d=%0d b_out=%b ovf=%b", i, d, b_out, ovf, ed, eb, eo);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_one_cycle[%0d]: got done=%b required 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rx, ry, ed;
    logic rb, eb, eo;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      rx = W'($urandom); ry = W'($urandom); rb = 1'($urandom);
      do_op(rx, ry, rb, 1'b0, lat, bc);
      model(int'(rx), int'(ry), int'(rb), ed, eb, eo);
      checks++;
      if (lat != W || d !== ed || b_out !== eb || ovf !== eo) begin
        errors++;
        $display("FAIL random[%0d]: got lat=%0d d=%0d b_out=%b ovf=%b required lat=%0d d=%0d b_out=%b ovf=%b", i, lat, d, b_out, ovf, W, ed, eb, eo);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    do_op(4'd7, 4'd3, 1'b0, 1'b1, lat, bc);
    checks++;
    if (lat != W || d !== 4'd4 || b_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_result: got lat=%0d d=%0d b_out=%b ovf=%b required lat=%0d d=4 b_out=0 ovf=0", lat, d, b_out, ovf, W);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL start_ignored_no_queue[%0d]: got busy=%b done=%b required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_hold();
    int lat, bc;
    do_op(4'd6, 4'd2, 1'b0, 1'b0, lat, bc);
    tick();
    x = 4'd3; y = 4'd7; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (busy !== 1'b1 || d !== 4'd4 || b_out !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL hold_during_shift[%0d]: got busy=%b d=%0d b_out=%b ovf=%b required busy=1 d=4 b_out=0 ovf=0", i, busy, d, b_out, ovf);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || d !== 4'd12 || b_out !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL hold_next_result: got done=%b d=%0d b_out=%b ovf=%b required done=1 d=12 b_out=1 ovf=0", done, d, b_out, ovf);
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    localparam int N = 30;
    logic [W-1:0] ox[N];
    logic [W-1:0] oy[N];
    logic         ob[N];
    logic [W-1:0] ed;
    logic eb, eo;
    bit exp_done;
    start = 1'b1;
    for (int t = 0; t < N; t++) begin
      ox[t] = W'($urandom); oy[t] = W'($urandom); ob[t] = 1'($urandom);
      x = ox[t]; y = oy[t]; b_in = ob[t];
      tick();
      // Accepts happen at edges 0, W+1, 2(W+1), ...; each result appears W edges later.
      exp_done = ((t % (W + 1)) == W);
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done[%0d]: got done=%b required %b", t, done, exp_done);
      end
      if (exp_done) begin
        model(int'(ox[t-W]), int'(oy[t-W]), int'(ob[t-W]), ed, eb, eo);
        $display("b2b x=%0d y=%0d b_in=%0d -> d=%0d b_out=%0d ovf=%0d", ox[t-W], oy[t-W], ob[t-W], d, b_out, ovf);
        checks++;
        if (d !== ed || b_out !== eb || ovf !== eo) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got d=%0d b_out=%b ovf=%b required d=%0d b_out=%b ovf=%b", t, d, b_out, ovf, ed, eb, eo);
        end
      end
    end
    start = 1'b0;
    repeat (W + 3) tick();
  endtask

  task automatic test_reset_abort();
    int lat, bc;
    bit seen_done;
    do_op(4'd7, 4'd3, 1'b0, 1'b0, lat, bc);
    tick();
    x = 4'd7; y = 4'd3; b_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, d, b_out, ovf} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b d=%0d b_out=%b ovf=%b required all 0", busy, done, d, b_out, ovf);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || d !== '0) begin
      errors++;
      $display("FAIL abort_no_done: got done_seen=%b d=%0d required 0 0", seen_done, d);
    end
    do_op(4'd5, 4'd5, 1'b0, 1'b0, lat, bc);
    checks++;
    if (done !== 1'b1 || lat != W || d !== 4'd0 || b_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: got done=%b lat=%0d d=%0d b_out=%b ovf=%b required done=1 lat=%0d d=0 b_out=0 ovf=0", done, lat, d, b_out, ovf, W);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
